pipe_host_bridge: RTL and testbench
===================================

PIPE_HOST_BRIDGE -- requirements
Module: pipe_host_bridge

Interface
REQ-001 Parameter DATA_W, default 32: host/memory data width in bits.
REQ-002 Parameter IMEM_AW, default 9: instruction-memory address width in bits.
REQ-003 Parameter DMEM_AW, default 8: data-memory address width in bits.
REQ-004 Parameter RD_LAT, default 1, legal range 1..4: memory read latency in cycles.
REQ-005 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 host_cmd  in  32  host command: [0] go, [1] write(1)/read(0), [2] target DMEM(1)/IMEM(0), [7] cpu_enable; other bits SHALL be ignored.
REQ-008 host_addr  in  32  host word address.
REQ-009 host_wdata  in  DATA_W  host write data.
REQ-010 host_rdata  out  DATA_W  read-back data, registered.
REQ-011 host_status  out  32  {16'count, 8'b0, 2'b0, err_cpu, err_addr, state[1:0], done, busy}, with busy at bit 0.
REQ-012 cpu_pc / cpu_daddr / cpu_dwe / cpu_dwdata  in  IMEM_AW / DMEM_AW / 1 / DATA_W  datapath-side memory requests.
REQ-013 imem_addr, imem_din, imem_we, imem_dout  out/out/out/in  IMEM_AW/DATA_W/1/DATA_W  instruction-memory port.
REQ-014 dmem_addr, dmem_din, dmem_we, dmem_dout  out/out/out/in  DMEM_AW/DATA_W/1/DATA_W  data-memory port.
REQ-015 cpu_run  out  1  datapath stall control; 0 SHALL freeze the PC and all pipeline registers.

Function
REQ-016 go SHALL pass through a 2-flop synchroniser; a start SHALL be the rising edge of the synchronised go.
REQ-017 FSM states: IDLE=0, CAPTURE=1, ACCESS=2, DONE=3.
REQ-018 IDLE, start, cpu_enable=1 -> err_cpu set (sticky), no access, remain IDLE.
REQ-019 IDLE, start, cpu_enable=0 -> CAPTURE; the cycle of the transition SHALL register addr, wdata, write and target.
REQ-020 Captured host_addr bits above the target AW nonzero -> err_addr set (sticky), no memory access, CAPTURE -> DONE.
REQ-021 CAPTURE -> ACCESS the next cycle; a write SHALL assert the target we for exactly one cycle (the ACCESS cycle) with the captured addr and data stable throughout.
REQ-022 Read: ACCESS SHALL last RD_LAT+1 cycles (counter); on the last ACCESS cycle the target dout SHALL be registered into host_rdata.
REQ-023 ACCESS -> DONE; count SHALL increment by 1 (16-bit wrap from 0xFFFF to 0) per completed access; error-aborted commands SHALL NOT count.
REQ-024 DONE: done=1; -> IDLE when synchronised go=0; a held go SHALL NOT retrigger.
REQ-025 busy=1 in CAPTURE and ACCESS, else 0.
REQ-026 Outside CAPTURE/ACCESS, memory ports SHALL carry cpu_pc, cpu_daddr, cpu_dwe, cpu_dwdata; imem_we SHALL be 0.
REQ-027 During CAPTURE/ACCESS, cpu_dwe SHALL be blocked from dmem_we.
REQ-028 cpu_run = cpu_enable AND state==IDLE (combinational); cpu_enable rising mid-operation SHALL NOT abort it, and the datapath stays frozen until IDLE.
REQ-029 Errors SHALL clear only on a start accepted with cpu_enable=0, or on reset.
REQ-030 Host-side inputs other than go SHALL be sampled only in the IDLE->CAPTURE cycle.

Reset
REQ-031 rst SHALL force: state IDLE, synchroniser 0, host_rdata 0, count 0, errors 0, done 0, busy 0, and all we outputs 0 immediately (asynchronously).
REQ-032 rst mid-ACCESS SHALL suppress any pending write; after release, one start edge is required before any access.

Verification
REQ-033 cpu_enable=0, write IMEM addr 5 data 0xDEADBEEF, go 0->1 -> one imem_we pulse with addr 5, done=1, count=1.
REQ-034 Read back IMEM addr 5, RD_LAT=2 -> host_rdata=0xDEADBEEF exactly 3 cycles after the ACCESS entry edge; imem_we stays 0.
REQ-035 go rise with cpu_enable=1 -> err_cpu=1, no we pulse, count unchanged, cpu_run stays 1.
REQ-036 DMEM write with host_addr=0x100 (DMEM_AW=8) -> err_addr=1, done=1, no dmem_we, count unchanged.
REQ-037 go held high for 20 cycles -> exactly one access; cpu_enable raised during ACCESS -> cpu_run=0 until IDLE.
REQ-038 rst asserted in ACCESS of a write -> dmem_we=0 at once, all status 0, no memory write.

Source files
------------

// File: rtl/pipe_host_bridge.sv
// Host-side access bridge: lets a host read/write instruction and data memory while the
// pipelined datapath is frozen, and hands both memory ports back to the datapath otherwise.
`timescale 1ns/1ps
module pipe_host_bridge #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 9,
    parameter int DMEM_AW = 8,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        host_cmd,
    input  logic [31:0]        host_addr,
    input  logic [DATA_W-1:0]  host_wdata,
    output logic [DATA_W-1:0]  host_rdata,
    output logic [31:0]        host_status,
    input  logic [IMEM_AW-1:0] cpu_pc,
    input  logic [DMEM_AW-1:0] cpu_daddr,
    input  logic               cpu_dwe,
    input  logic [DATA_W-1:0]  cpu_dwdata,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_din,
    output logic               imem_we,
    input  logic [DATA_W-1:0]  imem_dout,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_din,
    output logic               dmem_we,
    input  logic [DATA_W-1:0]  dmem_dout,
    output logic               cpu_run
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [2:0] LAST_CNT = 3'(RD_LAT);

    state_e            state_q;
    logic              go_meta_q, go_sync_q, go_prev_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              write_q, tgt_dmem_q;
    logic [2:0]        acc_cnt_q;
    logic [15:0]       count_q;
    logic              err_cpu_q, err_addr_q, busy_q, done_q;
    logic              imem_we_q, dmem_we_q;

    logic start, cpu_enable, addr_err, host_phase, unused_cmd;

    assign cpu_enable = host_cmd[7];
    assign start      = go_sync_q & ~go_prev_q;
    assign unused_cmd = ^{host_cmd[31:8], host_cmd[6:3]};

    // Any captured address bit above the selected memory's width makes the command illegal.
    assign addr_err = tgt_dmem_q ? ((addr_q >> DMEM_AW) != 32'd0)
                                 : ((addr_q >> IMEM_AW) != 32'd0);

    // NOTE: all state below resets asynchronously and is updated with non-blocking
    // assignments only, so every register samples the pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            go_meta_q  <= 1'b0;
            go_sync_q  <= 1'b0;
            go_prev_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            write_q    <= 1'b0;
            tgt_dmem_q <= 1'b0;
            acc_cnt_q  <= '0;
            count_q    <= '0;
            err_cpu_q  <= 1'b0;
            err_addr_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            imem_we_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
        end else begin
            go_meta_q <= host_cmd[0];
            go_sync_q <= go_meta_q;
            go_prev_q <= go_sync_q;
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (cpu_enable) begin
                            err_cpu_q <= 1'b1;
                        end else begin
                            addr_q     <= host_addr;
                            wdata_q    <= host_wdata;
                            write_q    <= host_cmd[1];
                            tgt_dmem_q <= host_cmd[2];
                            err_cpu_q  <= 1'b0;
                            err_addr_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (addr_err) begin
                        err_addr_q <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        acc_cnt_q <= '0;
                        imem_we_q <= write_q & ~tgt_dmem_q;
                        dmem_we_q <= write_q & tgt_dmem_q;
                        state_q   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Writes complete in one cycle; reads wait out the memory latency.
                    if (write_q || acc_cnt_q == LAST_CNT) begin
                        if (!write_q) begin
                            rdata_q <= tgt_dmem_q ? dmem_dout : imem_dout;
                        end
                        count_q <= count_q + 16'd1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        acc_cnt_q <= acc_cnt_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (!go_sync_q) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the port steering is a pure mux off registered state, so the datapath keeps
    // zero-latency access to both memories whenever the host is not using them.
    assign host_phase = busy_q;
    assign imem_addr  = (host_phase && !tgt_dmem_q) ? addr_q[IMEM_AW-1:0] : cpu_pc;
    assign imem_din   = wdata_q;
    assign imem_we    = imem_we_q;
    assign dmem_addr  = (host_phase && tgt_dmem_q) ? addr_q[DMEM_AW-1:0] : cpu_daddr;
    assign dmem_din   = (host_phase && tgt_dmem_q) ? wdata_q : cpu_dwdata;
    assign dmem_we    = !rst && (host_phase ? dmem_we_q : cpu_dwe);

    assign cpu_run     = cpu_enable && (state_q == ST_IDLE);
    assign host_rdata  = rdata_q;
    assign host_status = {count_q, 8'd0, 2'd0, err_cpu_q, err_addr_q, state_q, done_q, busy_q};

endmodule

// File: tb/tb_pipe_host_bridge.sv
// Bench for pipe_host_bridge: directed host commands against a latency-accurate memory model,
// a shadow memory/counter model, and a per-cycle monitor of the port-steering rules.
`timescale 1ns/1ps
module tb_pipe_host_bridge;

    localparam int DATA_W  = 32;
    localparam int IMEM_AW = 9;
    localparam int DMEM_AW = 8;
    localparam int RD_LAT  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        host_cmd, host_addr;
    logic [DATA_W-1:0]  host_wdata, host_rdata;
    logic [31:0]        host_status;
    logic [IMEM_AW-1:0] cpu_pc;
    logic [DMEM_AW-1:0] cpu_daddr;
    logic               cpu_dwe;
    logic [DATA_W-1:0]  cpu_dwdata;
    logic [IMEM_AW-1:0] imem_addr;
    logic [DATA_W-1:0]  imem_din, imem_dout;
    logic               imem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_din, dmem_dout;
    logic               dmem_we;
    logic               cpu_run;

    pipe_host_bridge #(
        .DATA_W (DATA_W),
        .IMEM_AW(IMEM_AW),
        .DMEM_AW(DMEM_AW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host_cmd   (host_cmd),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_status(host_status),
        .cpu_pc     (cpu_pc),
        .cpu_daddr  (cpu_daddr),
        .cpu_dwe    (cpu_dwe),
        .cpu_dwdata (cpu_dwdata),
        .imem_addr  (imem_addr),
        .imem_din   (imem_din),
        .imem_we    (imem_we),
        .imem_dout  (imem_dout),
        .dmem_addr  (dmem_addr),
        .dmem_din   (dmem_din),
        .dmem_we    (dmem_we),
        .dmem_dout  (dmem_dout),
        .cpu_run    (cpu_run)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Synchronous-read memories with RD_LAT cycles of read latency.
    logic              mem_clr;
    logic [DATA_W-1:0] imem_arr  [2**IMEM_AW];
    logic [DATA_W-1:0] dmem_arr  [2**DMEM_AW];
    logic [DATA_W-1:0] imem_pipe [RD_LAT];
    logic [DATA_W-1:0] dmem_pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 2**IMEM_AW; i++) imem_arr[i] <= '0;
            for (int i = 0; i < 2**DMEM_AW; i++) dmem_arr[i] <= '0;
        end else begin
            if (imem_we) imem_arr[imem_addr] <= imem_din;
            if (dmem_we) dmem_arr[dmem_addr] <= dmem_din;
        end
        imem_pipe[0] <= imem_arr[imem_addr];
        dmem_pipe[0] <= dmem_arr[dmem_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            imem_pipe[i] <= imem_pipe[i-1];
            dmem_pipe[i] <= dmem_pipe[i-1];
        end
    end
    assign imem_dout = imem_pipe[RD_LAT-1];
    assign dmem_dout = dmem_pipe[RD_LAT-1];

    // Reference model: expected memory contents, completed-access count and error flags.
    logic [DATA_W-1:0] exp_imem [2**IMEM_AW];
    logic [DATA_W-1:0] exp_dmem [2**DMEM_AW];
    logic [15:0]       exp_count;
    logic              exp_err_cpu, exp_err_addr;

    // Per-cycle monitor of the steering/status rules; counts host write pulses.
    logic              chk_en = 1'b0;
    logic [1:0]        mon_st;
    int                n_imem_pulse = 0;
    int                n_dmem_pulse = 0;
    logic [31:0]       pulse_addr;
    logic [DATA_W-1:0] pulse_data;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            mon_st = host_status[3:2];
            check("busy_bit", host_status[0], (mon_st == 2'd1 || mon_st == 2'd2));
            check("done_bit", host_status[1], (mon_st == 2'd3));
            check("reserved_bits", host_status[15:6], 10'd0);
            check("cpu_run", cpu_run, (host_cmd[7] && mon_st == 2'd0));
            if (mon_st == 2'd0 || mon_st == 2'd3) begin
                check("imem_passthru", {imem_addr, imem_we}, {cpu_pc, 1'b0});
                check("dmem_passthru", {dmem_addr, dmem_din, dmem_we}, {cpu_daddr, cpu_dwdata, cpu_dwe});
                check("count_field", host_status[31:16], exp_count);
            end else begin
                if (mon_st == 2'd1) check("capture_no_we", {imem_we, dmem_we}, 2'b00);
                if (imem_we) begin
                    n_imem_pulse++;
                    pulse_addr = 32'(imem_addr);
                    pulse_data = imem_din;
                end
                if (dmem_we) begin
                    n_dmem_pulse++;
                    pulse_addr = 32'(dmem_addr);
                    pulse_data = dmem_din;
                end
            end
        end
    end

    task automatic host_op(input bit wr, input bit dm, input logic [31:0] addr,
                           input logic [DATA_W-1:0] wd, input bit en, input bit en_mid,
                           input int hold);
        int                cyc, acc_k, done_len, imem0, dmem0, aw;
        bit                seen_done, scrambled, bad;
        logic [DATA_W-1:0] rdata_before;
        aw           = dm ? DMEM_AW : IMEM_AW;
        bad          = ((addr >> aw) != 32'd0);
        imem0        = n_imem_pulse;
        dmem0        = n_dmem_pulse;
        rdata_before = host_rdata;
        host_addr    = addr;
        host_wdata   = wd;
        host_cmd     = {24'hA5A5A5, en, 4'b1010, dm, wr, 1'b1};
        cyc = 0; acc_k = -1; done_len = -1; seen_done = 0; scrambled = 0;
        while (cyc < hold || (!en && !seen_done && cyc < 60)) begin
            step();
            cyc++;
            if (host_status[3:2] != 2'd0 && !scrambled) begin
                host_addr  = ~addr;
                host_wdata = ~wd;
                scrambled  = 1;
            end
            if (!seen_done) begin
                if (acc_k >= 0) acc_k++;
                else if (host_status[3:2] == 2'd2) begin
                    acc_k = 0;
                    if (en_mid) host_cmd[7] = 1'b1;
                end
                if (!wr && host_status[3:2] == 2'd2 && acc_k == RD_LAT)
                    check("rdata_held_before_last", host_rdata, rdata_before);
                if (host_status[3:2] == 2'd3) begin
                    seen_done = 1;
                    done_len  = acc_k;
                    if (!en && !bad) exp_count = exp_count + 16'd1;
                end
            end
        end
        if (en) begin
            exp_err_cpu = 1'b1;
            check("cpu_err_stays_idle", host_status[3:2], 2'd0);
        end else begin
            exp_err_cpu  = 1'b0;
            exp_err_addr = bad;
            check("done_reached", seen_done, 1'b1);
            if (bad) begin
                check("addr_err_no_access", (acc_k >= 0), 1'b0);
            end else begin
                check("access_len", done_len, wr ? 1 : RD_LAT + 1);
                if (wr) begin
                    check("we_addr", pulse_addr, dm ? 32'(addr[DMEM_AW-1:0]) : 32'(addr[IMEM_AW-1:0]));
                    check("we_data", pulse_data, wd);
                    if (dm) exp_dmem[addr[DMEM_AW-1:0]] = wd;
                    else    exp_imem[addr[IMEM_AW-1:0]] = wd;
                end else begin
                    check("rdata", host_rdata, dm ? exp_dmem[addr[DMEM_AW-1:0]] : exp_imem[addr[IMEM_AW-1:0]]);
                end
            end
        end
        check("err_cpu", host_status[5], exp_err_cpu);
        check("err_addr", host_status[4], exp_err_addr);
        check("imem_pulses", n_imem_pulse - imem0, (!en && !bad && wr && !dm) ? 1 : 0);
        check("dmem_pulses", n_dmem_pulse - dmem0, (!en && !bad && wr && dm) ? 1 : 0);
        check("count_after_op", host_status[31:16], exp_count);
        if (en_mid) check("cpu_run_frozen_in_done", cpu_run, 1'b0);
        host_cmd[0] = 1'b0;
        cyc = 0;
        while (host_status[3:2] != 2'd0 && cyc < 10) begin
            step();
            cyc++;
        end
        check("back_to_idle", host_status[3:2], 2'd0);
        if (en_mid) begin
            check("cpu_run_after_idle", cpu_run, 1'b1);
            host_cmd[7] = 1'b0;
        end
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        int cyc;
        rst        = 1'b1;
        mem_clr    = 1'b1;
        host_cmd   = '0;
        host_addr  = '0;
        host_wdata = '0;
        cpu_pc     = 9'h0AB;
        cpu_daddr  = 8'h44;
        cpu_dwe    = 1'b1;
        cpu_dwdata = 32'h0;
        exp_count  = '0;
        exp_err_cpu  = 1'b0;
        exp_err_addr = 1'b0;
        for (int i = 0; i < 2**IMEM_AW; i++) exp_imem[i] = '0;
        for (int i = 0; i < 2**DMEM_AW; i++) exp_dmem[i] = '0;

        repeat (3) step();
        check("reset_status", host_status, 32'h0);
        check("reset_rdata", host_rdata, 32'h0);
        check("reset_imem_we", imem_we, 1'b0);
        check("reset_dmem_we", dmem_we, 1'b0);
        check("reset_cpu_run", cpu_run, 1'b0);
        mem_clr = 1'b0;
        cpu_dwe = 1'b0;
        rst     = 1'b0;
        chk_en  = 1'b1;
        repeat (4) step();

        host_op(1, 0, 32'd5, 32'hDEADBEEF, 0, 0, 10);
        check("lit_status_after_write", host_status, 32'h0001_0000);

        host_op(0, 0, 32'd5, 32'h0, 0, 0, 10);
        check("lit_rdata_deadbeef", host_rdata, 32'hDEADBEEF);
        check("lit_count_2", host_status[31:16], 16'd2);

        host_op(0, 0, 32'd5, 32'h0, 1, 0, 10);
        check("lit_status_err_cpu", host_status, 32'h0002_0020);

        host_op(1, 1, 32'h100, 32'h11111111, 0, 0, 10);
        check("lit_status_err_addr", host_status, 32'h0002_0010);

        host_op(1, 1, 32'hFF, 32'hA5A5A5A5, 0, 0, 10);
        host_op(0, 1, 32'hFF, 32'h0, 0, 0, 10);
        check("lit_rdata_a5", host_rdata, 32'hA5A5A5A5);
        host_op(1, 0, 32'h1FF, 32'h13579BDF, 0, 0, 10);
        host_op(0, 0, 32'h1FF, 32'h0, 0, 0, 10);
        host_op(1, 0, 32'h200, 32'h22222222, 0, 0, 10);
        check("lit_count_6", host_status[31:16], 16'd6);

        host_op(1, 1, 32'h10, 32'h0F0F0F0F, 0, 1, 20);
        check("lit_count_7", host_status[31:16], 16'd7);

        cpu_daddr  = 8'h20;
        cpu_dwdata = 32'hCAFEF00D;
        cpu_dwe    = 1'b1;
        repeat (2) step();
        exp_dmem[8'h20] = 32'hCAFEF00D;
        host_op(0, 0, 32'd5, 32'h0, 0, 0, 10);
        cpu_dwe = 1'b0;
        host_op(0, 1, 32'h20, 32'h0, 0, 0, 10);
        check("lit_rdata_cpu_write", host_rdata, 32'hCAFEF00D);

        host_op(1, 1, 32'h30, 32'h0BADF00D, 0, 0, 10);
        host_addr  = 32'h30;
        host_wdata = 32'h12345678;
        host_cmd   = 32'h0000_0007;
        cyc = 0;
        while (host_status[3:2] != 2'd2 && cyc < 20) begin
            step();
            cyc++;
        end
        check("mid_rst_in_access", host_status[3:2], 2'd2);
        check("mid_rst_we_active", dmem_we, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_dmem_we", dmem_we, 1'b0);
        check("mid_rst_status", host_status, 32'h0);
        check("mid_rst_rdata", host_rdata, 32'h0);
        exp_count    = '0;
        exp_err_cpu  = 1'b0;
        exp_err_addr = 1'b0;
        host_cmd     = '0;
        repeat (3) step();
        rst = 1'b0;
        repeat (6) step();
        check("post_rst_idle", host_status, 32'h0);
        host_op(0, 1, 32'h30, 32'h0, 0, 0, 10);
        check("lit_write_suppressed", host_rdata, 32'h0BADF00D);
        check("lit_count_after_rst", host_status[31:16], 16'd1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
